// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared screen constants and ball state type for the pong engine
package pong_pkg;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;
   localparam int COORD_W  = 11;

   typedef enum logic [1:0] {
      SERVE  = 2'd0,
      MOVING = 2'd1,
      MISSED = 2'd2
   } ball_state_t;

endpackage

// File: rtl/ball_axis.sv
// rtl/ball_axis.sv - one axis of ball position/direction with wall reflect and clamp
module ball_axis
   import pong_pkg::*;
#(
   parameter int W          = 10,
   parameter int SPEED      = 2,
   parameter int HIGH_LIMIT = 632,
   parameter int CENTER     = 316
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         step,
   input  logic         force_reflect,
   input  logic [W-1:0] force_pos,
   input  logic         recenter,
   input  logic         recenter_flip,
   output logic [W-1:0] pos,
   output logic         dir_high,
   output logic         hit_high
);

   localparam logic [COORD_W-1:0] SPEED_C = COORD_W'(SPEED);
   localparam logic [COORD_W-1:0] HIGH_C  = COORD_W'(HIGH_LIMIT);

   logic [COORD_W-1:0] pos_w;
   logic               hit_low;

   // Widened copy keeps pos+SPEED from wrapping near the far wall.
   assign pos_w    = COORD_W'(pos);
   assign hit_high = dir_high && ((pos_w + SPEED_C) >= HIGH_C);
   assign hit_low  = !dir_high && (pos_w <= SPEED_C);

   always_ff @(posedge clk) begin
      if (reset) begin
         pos      <= W'(CENTER);
         dir_high <= 1'b1;
      end else if (recenter) begin
         pos      <= W'(CENTER);
         dir_high <= recenter_flip ? ~dir_high : 1'b1;
      end else if (step) begin
         if (force_reflect) begin
            pos      <= force_pos;
            dir_high <= 1'b0;
         end else if (hit_high) begin
            pos      <= W'(HIGH_LIMIT);
            dir_high <= 1'b0;
         end else if (dir_high) begin
            pos <= pos + W'(SPEED);
         end else if (hit_low) begin
            pos      <= '0;
            dir_high <= 1'b1;
         end else begin
            pos <= pos - W'(SPEED);
         end
      end
   end

endmodule

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - pong ball engine: serve/move/miss FSM, paddle bounce, pixel draw
module ball_controller
   import pong_pkg::*;
#(
   parameter int BALL_SIZE    = 8,
   parameter int SPEED        = 2,
   parameter int PADDLE_WIDTH = 64,
   parameter int PADDLE_Y     = 464,
   parameter int SERVE_FRAMES = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       visible,
   input  logic [9:0] x,
   input  logic [8:0] y,
   input  logic [9:0] paddle_x,
   output logic       ball_pixel,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic       miss,
   output logic       serving
);

   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [COORD_W-1:0] BS_C  = COORD_W'(BALL_SIZE);
   localparam logic [COORD_W-1:0] SP_C  = COORD_W'(SPEED);
   localparam logic [COORD_W-1:0] PW_C  = COORD_W'(PADDLE_WIDTH);
   localparam logic [COORD_W-1:0] PY_C  = COORD_W'(PADDLE_Y);
   localparam logic [CNT_W-1:0]   LAST_C = CNT_W'(SERVE_FRAMES - 1);

   ball_state_t        state, state_next;
   logic [CNT_W-1:0]   cnt, cnt_next;
   logic               move_step, recenter, miss_next;
   logic               y_down, y_hit_high, x_dir, x_hit_high;
   logic               paddle_hit;
   logic [COORD_W-1:0] x_w, y_w, px_w, bx_w, by_w, bottom_w;
   logic               pixel_next;
   logic               x_unused;

   assign x_unused = x_dir ^ x_hit_high;

   ball_axis #(
      .W          (10),
      .SPEED      (SPEED),
      .HIGH_LIMIT (H_ACTIVE - BALL_SIZE),
      .CENTER     ((H_ACTIVE - BALL_SIZE) / 2)
   ) u_axis_x (
      .clk           (clk),
      .reset         (reset),
      .step          (move_step),
      .force_reflect (1'b0),
      .force_pos     (10'd0),
      .recenter      (recenter),
      .recenter_flip (1'b1),
      .pos           (ball_x),
      .dir_high      (x_dir),
      .hit_high      (x_hit_high)
   );

   // Paddle reflection overrides the bottom-wall clamp on the vertical axis.
   ball_axis #(
      .W          (9),
      .SPEED      (SPEED),
      .HIGH_LIMIT (V_ACTIVE - BALL_SIZE),
      .CENTER     ((V_ACTIVE - BALL_SIZE) / 2)
   ) u_axis_y (
      .clk           (clk),
      .reset         (reset),
      .step          (move_step),
      .force_reflect (paddle_hit),
      .force_pos     (9'(PADDLE_Y - BALL_SIZE)),
      .recenter      (recenter),
      .recenter_flip (1'b0),
      .pos           (ball_y),
      .dir_high      (y_down),
      .hit_high      (y_hit_high)
   );

   assign bx_w     = COORD_W'(ball_x);
   assign by_w     = COORD_W'(ball_y);
   assign px_w     = COORD_W'(paddle_x);
   assign x_w      = COORD_W'(x);
   assign y_w      = COORD_W'(y);
   assign bottom_w = by_w + BS_C;

   // Overlap uses the pre-move horizontal position.
   assign paddle_hit = y_down
                    && (bottom_w <= PY_C)
                    && ((bottom_w + SP_C) >= PY_C)
                    && ((bx_w + BS_C) > px_w)
                    && (bx_w < (px_w + PW_C));

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      move_step  = 1'b0;
      recenter   = 1'b0;
      miss_next  = 1'b0;
      if (frame_tick) begin
         case (state)
            SERVE: begin
               if (cnt == LAST_C) begin
                  state_next = MOVING;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + 1'b1;
               end
            end
            MOVING: begin
               move_step = 1'b1;
               if (y_hit_high && !paddle_hit) begin
                  state_next = MISSED;
                  miss_next  = 1'b1;
               end
            end
            MISSED: begin
               recenter   = 1'b1;
               state_next = SERVE;
               cnt_next   = '0;
            end
            default: state_next = SERVE;
         endcase
      end
   end

   assign pixel_next = visible
                    && (x_w >= bx_w) && (x_w < (bx_w + BS_C))
                    && (y_w >= by_w) && (y_w < (by_w + BS_C));

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= SERVE;
         cnt        <= '0;
         miss       <= 1'b0;
         ball_pixel <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         miss       <= miss_next;
         ball_pixel <= pixel_next;
      end
   end

   assign serving = (state == SERVE);

endmodule

// File: tb/tb_ball_controller.sv
// tb/tb_ball_controller.sv - scoreboard bench for the pong ball engine
module tb_ball_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       frame_tick = 1'b0;
   logic       visible = 1'b0;
   logic [9:0] x = '0;
   logic [8:0] y = '0;
   logic [9:0] paddle_x = '0;
   logic       ball_pixel;
   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic       miss;
   logic       serving;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ball_controller dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .visible    (visible),
      .x          (x),
      .y          (y),
      .paddle_x   (paddle_x),
      .ball_pixel (ball_pixel),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .miss       (miss),
      .serving    (serving)
   );

   typedef struct {
      int bx;
      int by;
      bit srv;
      bit mi;
   } exp_t;

   exp_t exp_q[$];
   bit   pix_q[$];

   // Reference model: 0=serve, 1=moving, 2=missed
   int m_state, m_cnt, m_x, m_y;
   bit m_right, m_down;

   task automatic model_reset();
      m_state = 0; m_cnt = 0; m_x = 316; m_y = 236; m_right = 1; m_down = 1;
   endtask

   task automatic model_tick(output bit mi);
      int px;
      int ox;
      int oy;
      bit hit;
      mi = 0;
      px = int'(paddle_x);
      ox = m_x;
      oy = m_y;
      case (m_state)
         0: begin
            if (m_cnt == 59) begin m_state = 1; m_cnt = 0; end
            else m_cnt = m_cnt + 1;
         end
         1: begin
            hit = m_down && (oy + 8 <= 464) && (oy + 10 >= 464) && (ox + 8 > px) && (ox < px + 64);
            if (m_right) begin
               if (ox + 2 >= 632) begin m_x = 632; m_right = 0; end
               else m_x = ox + 2;
            end else begin
               if (ox <= 2) begin m_x = 0; m_right = 1; end
               else m_x = ox - 2;
            end
            if (!m_down) begin
               if (oy <= 2) begin m_y = 0; m_down = 1; end
               else m_y = oy - 2;
            end else if (hit) begin
               m_y = 456; m_down = 0;
            end else if (oy + 2 >= 472) begin
               m_y = 472; m_state = 2; mi = 1;
            end else begin
               m_y = oy + 2;
            end
         end
         default: begin
            m_x = 316; m_y = 236; m_down = 1; m_right = !m_right; m_state = 0; m_cnt = 0;
         end
      endcase
   endtask

   // Drives one clock with the given tick and pushes the expected outcome.
   task automatic cycle(input bit tk);
      exp_t e;
      bit   mi;
      bit   px;
      @(negedge clk);
      frame_tick = tk;
      mi = 0;
      px = visible && (int'(x) >= m_x) && (int'(x) < m_x + 8) && (int'(y) >= m_y) && (int'(y) < m_y + 8);
      if (reset) begin
         model_reset();
         px = 0;
      end else if (tk) begin
         model_tick(mi);
      end
      e.bx = m_x; e.by = m_y; e.srv = (m_state == 0); e.mi = mi;
      exp_q.push_back(e);
      pix_q.push_back(px);
      @(posedge clk);
      #1;
      frame_tick = 0;
   endtask

   task automatic do_reset();
      exp_t e;
      reset = 1;
      cycle(1'b0);
      reset = 0;
      e = exp_q.pop_front();
      exp_q.delete();
      pix_q.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      bit   p;
      reset = 1;
      cycle(1'b1);
      reset = 0;
      e = exp_q.pop_front();
      p = pix_q.pop_front();
      checks++;
      if (ball_x !== 10'd316 || ball_y !== 9'd236 || serving !== 1'b1 || miss !== 1'b0 || ball_pixel !== p) begin
         errors++;
         $display("FAIL reset_state: got x=%0d y=%0d srv=%0b miss=%0b pix=%0b want x=316 y=236 srv=1 miss=0 pix=0",
                  ball_x, ball_y, serving, miss, ball_pixel);
      end
   endtask

   task automatic test_serve();
      exp_t e;
      do_reset();
      for (int i = 1; i <= 61; i++) begin
         cycle(1'b1);
         e = exp_q.pop_front();
         checks++;
         if (ball_x !== e.bx || ball_y !== e.by || serving !== e.srv || miss !== e.mi) begin
            errors++;
            $display("FAIL serve_tick%0d: got x=%0d y=%0d srv=%0b miss=%0b want x=%0d y=%0d srv=%0b miss=%0b",
                     i, ball_x, ball_y, serving, miss, e.bx, e.by, e.srv, e.mi);
         end
         if (i == 59) begin
            checks++;
            if (serving !== 1'b1 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
               errors++;
               $display("FAIL serve_59: got srv=%0b x=%0d y=%0d want srv=1 x=316 y=236", serving, ball_x, ball_y);
            end
         end
         if (i == 60) begin
            checks++;
            if (serving !== 1'b0 || ball_x !== 10'd316 || ball_y !== 9'd236) begin
               errors++;
               $display("FAIL launch_60: got srv=%0b x=%0d y=%0d want srv=0 x=316 y=236", serving, ball_x, ball_y);
            end
         end
         if (i == 61) begin
            checks++;
            if (ball_x !== 10'd318 || ball_y !== 9'd238) begin
               errors++;
               $display("FAIL first_move: got x=%0d y=%0d want x=318 y=238", ball_x, ball_y);
            end
         end
      end
   endtask

   task automatic test_paddle_bounce();
      exp_t e;
      int   prev_y;
      do_reset();
      paddle_x = 10'd500;
      repeat (60) cycle(1'b1);
      exp_q.delete();
      prev_y = 236;
      for (int k = 1; k <= 159; k++) begin
         cycle(1'b1);
         e = exp_q.pop_front();
         checks++;
         if (ball_x !== e.bx || ball_y !== e.by || serving !== e.srv || miss !== e.mi) begin
            errors++;
            $display("FAIL bounce_tick%0d: got x=%0d y=%0d srv=%0b miss=%0b want x=%0d y=%0d srv=%0b miss=%0b",
                     k, ball_x, ball_y, serving, miss, e.bx, e.by, e.srv, e.mi);
         end
         if (k == 110) begin
            checks++;
            if (ball_y !== 9'd456 || miss !== 1'b0) begin
               errors++;
               $display("FAIL paddle_hit: got y=%0d miss=%0b want y=456 miss=0", ball_y, miss);
            end
         end
         if (k == 111) begin
            checks++;
            if (ball_y !== 9'd454) begin
               errors++;
               $display("FAIL paddle_up: got y=%0d want 454", ball_y);
            end
         end
         if (k == 158) begin
            checks++;
            if (ball_x !== 10'd632) begin
               errors++;
               $display("FAIL right_wall: got x=%0d want 632", ball_x);
            end
         end
         if (k == 159) begin
            checks++;
            if (ball_x !== 10'd630 || int'(ball_y) >= prev_y) begin
               errors++;
               $display("FAIL right_reflect: got x=%0d y=%0d want x=630 y<%0d", ball_x, ball_y, prev_y);
            end
         end
         prev_y = int'(ball_y);
      end
   endtask

   task automatic test_miss();
      exp_t e;
      do_reset();
      paddle_x = 10'd0;
      repeat (60) cycle(1'b1);
      exp_q.delete();
      for (int k = 1; k <= 118; k++) begin
         cycle(1'b1);
         e = exp_q.pop_front();
         checks++;
         if (ball_x !== e.bx || ball_y !== e.by || serving !== e.srv || miss !== e.mi) begin
            errors++;
            $display("FAIL miss_tick%0d: got x=%0d y=%0d srv=%0b miss=%0b want x=%0d y=%0d srv=%0b miss=%0b",
                     k, ball_x, ball_y, serving, miss, e.bx, e.by, e.srv, e.mi);
         end
      end
      checks++;
      if (ball_y !== 9'd472 || miss !== 1'b1) begin
         errors++;
         $display("FAIL miss_pulse: got y=%0d miss=%0b want y=472 miss=1", ball_y, miss);
      end
      cycle(1'b0);
      e = exp_q.pop_front();
      checks++;
      if (miss !== e.mi || ball_y !== e.by) begin
         errors++;
         $display("FAIL miss_width: got miss=%0b y=%0d want miss=%0b y=%0d", miss, ball_y, e.mi, e.by);
      end
      cycle(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (serving !== 1'b1 || ball_x !== 10'd316 || ball_y !== 9'd236 || ball_x !== e.bx) begin
         errors++;
         $display("FAIL recentre: got srv=%0b x=%0d y=%0d want srv=1 x=316 y=236", serving, ball_x, ball_y);
      end
      repeat (60) cycle(1'b1);
      exp_q.delete();
      cycle(1'b1);
      e = exp_q.pop_front();
      checks++;
      if (ball_x !== 10'd314 || ball_y !== 9'd238 || ball_x !== e.bx) begin
         errors++;
         $display("FAIL relaunch_left: got x=%0d y=%0d want x=314 y=238", ball_x, ball_y);
      end
   endtask

   task automatic test_pixel();
      bit   p;
      exp_t e;
      int   vis_t[6] = '{1, 1, 0, 1, 1, 1};
      int   x_t[6]   = '{316, 324, 316, 323, 316, 315};
      int   y_t[6]   = '{236, 236, 236, 243, 244, 236};
      int   want_t[6] = '{1, 0, 0, 1, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         visible = vis_t[i][0];
         x = 10'(x_t[i]);
         y = 9'(y_t[i]);
         cycle(1'b0);
         p = pix_q.pop_front();
         e = exp_q.pop_front();
         checks++;
         if (ball_pixel !== p || ball_pixel !== want_t[i][0]) begin
            errors++;
            $display("FAIL pixel%0d: got %0b want %0b (model %0b)", i, ball_pixel, want_t[i][0], p);
         end
      end
      visible = 0;
      repeat (3) cycle(1'b1);
      repeat (56) cycle(1'b1);
      checks++;
      if (serving !== 1'b1) begin
         errors++;
         $display("FAIL held_tick_count: got srv=%0b want 1 after 59 counted ticks", serving);
      end
      cycle(1'b1);
      checks++;
      if (serving !== 1'b0) begin
         errors++;
         $display("FAIL held_tick_launch: got srv=%0b want 0 after 60 counted ticks", serving);
      end
      exp_q.delete();
      pix_q.delete();
   endtask

   task automatic test_reset_mid();
      exp_t e;
      bit   p;
      do_reset();
      paddle_x = 10'd0;
      repeat (60 + 117) cycle(1'b1);
      exp_q.delete();
      pix_q.delete();
      visible = 1;
      x = ball_x;
      y = ball_y;
      reset = 1;
      cycle(1'b1);
      reset = 0;
      e = exp_q.pop_front();
      p = pix_q.pop_front();
      checks++;
      if (ball_x !== e.bx || ball_y !== e.by || serving !== e.srv || miss !== e.mi || ball_pixel !== p
          || ball_x !== 10'd316 || ball_y !== 9'd236 || miss !== 1'b0 || ball_pixel !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: got x=%0d y=%0d srv=%0b miss=%0b pix=%0b want x=316 y=236 srv=1 miss=0 pix=0",
                  ball_x, ball_y, serving, miss, ball_pixel);
      end
      visible = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_serve();
      test_paddle_bounce();
      test_miss();
      test_pixel();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ball_controller.md
Name: ball_controller

Overview:
Pong ball engine for the 640x480 paddle game. It sits downstream of the h/v sync controllers and beside the paddle block, and consumes the pixel coordinates x/y plus the paddle position. Once per frame it moves the ball and reflects it off the walls and the paddle. It detects misses and produces a registered ball_pixel that the top level ORs into r/g/b.

Parameters:
BALL_SIZE, 8, ball edge length in pixels (square)
SPEED, 2, pixels moved per axis per frame
PADDLE_WIDTH, 64, paddle width in pixels
PADDLE_Y, 464, top row of the paddle
SERVE_FRAMES, 60, frames the ball waits at centre before launch
H_ACTIVE, 640, visible columns
V_ACTIVE, 480, visible rows

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-high
frame_tick  in  1  one-cycle pulse per frame, issued during vertical blanking
visible  in  1  current x/y is inside the active area
x  in  10  current pixel column
y  in  9  current pixel row
paddle_x  in  10  paddle left edge column
ball_pixel  out  1  current pixel belongs to the ball (registered)
ball_x  out  10  ball left edge
ball_y  out  9  ball top edge
miss  out  1  one-cycle pulse when the ball passes the paddle
serving  out  1  high while in SERVE

Behaviour:
- Reset (synchronous, active-high, all registers):
  - ball_x=316, ball_y=236 (centre, i.e. (H_ACTIVE-BALL_SIZE)/2 and (V_ACTIVE-BALL_SIZE)/2).
  - Direction right/down; state SERVE; serve counter 0.
  - miss=0, ball_pixel=0, serving=1.
  - frame_tick is ignored while reset is high.
- State, position and direction change only on clk edges where frame_tick=1. Every high cycle of frame_tick counts as one tick.
- States: SERVE, MOVING, MISSED.
- SERVE:
  - Ball is held at centre and the counter increments on each tick.
  - On the tick where counter==SERVE_FRAMES-1: go to MOVING, clear counter, keep position unchanged, drop serving.
- MOVING, per tick; both axes are evaluated independently in the same cycle, so a corner yields two reflections.
  - Horizontal, right: if ball_x+SPEED >= H_ACTIVE-BALL_SIZE, then ball_x=632 and direction becomes left; else ball_x+=SPEED.
  - Horizontal, left: if ball_x <= SPEED, then ball_x=0 and direction becomes right; else ball_x-=SPEED.
  - Vertical, up: if ball_y <= SPEED, then ball_y=0 and direction becomes down; else ball_y-=SPEED.
  - Vertical, down, paddle hit when all of these hold:
    - ball_y+BALL_SIZE <= PADDLE_Y;
    - ball_y+BALL_SIZE+SPEED >= PADDLE_Y;
    - ball_x+BALL_SIZE > paddle_x;
    - ball_x < paddle_x+PADDLE_WIDTH.
  - On a paddle hit: ball_y=PADDLE_Y-BALL_SIZE and direction becomes up. The check uses the pre-update ball_x.
  - Vertical, down, miss: else if ball_y+SPEED >= V_ACTIVE-BALL_SIZE, then ball_y=472, state becomes MISSED, and miss is high for exactly the next cycle. Otherwise ball_y+=SPEED.
  - Priority on the vertical axis: paddle hit > miss > plain move.
- MISSED:
  - Ball is drawn frozen at the bottom.
  - Next tick: recentre, vertical direction down, horizontal direction inverted, state SERVE, serving=1, counter 0.
- Arithmetic:
  - All comparisons are done at 11 bits, zero-extended, so that paddle_x+PADDLE_WIDTH and ball+SIZE cannot wrap.
  - Outputs are truncated to port widths; truncated values never exceed 639/479.
- ball_pixel is registered with 1-cycle latency. It is set when all of the following hold on the previous cycle:
  - visible=1;
  - ball_x <= x < ball_x+BALL_SIZE;
  - ball_y <= y < ball_y+BALL_SIZE.
- The ball is drawn in every state. With visible=0 the output is 0 regardless of x/y.
- Position updates land in vertical blanking, so no frame shows a torn ball.
- Reset mid-MOVING or mid-MISSED returns all outputs to their reset values on the next edge. A pending miss pulse is cancelled.

Decomposition:
- Package pong_pkg holds:
  - H_ACTIVE and V_ACTIVE screen constants;
  - typedef enum logic [1:0] ball_state_t {SERVE, MOVING, MISSED};
  - a COORD_W=11 comparison width constant.
- One natural sub-module: ball_axis. It holds the position and direction register for one axis, with step, low-wall reflect, and high-wall reflect/clamp, plus an external force_reflect input (paddle) and a hit_high output (miss detect). It is instantiated for x and y.
- The FSM, paddle overlap check and pixel compare stay in ball_controller.

Test Plan:
- Reset, then 59 frame_ticks -> serving=1, ball (316,236). 60th tick -> serving=0, position unchanged. Next tick -> (318,238).
- paddle_x=500 after launch -> tick 110 gives ball_y=456 with direction up; tick 111 gives ball_y=454; no miss.
- Continue the previous scenario -> tick 158 gives ball_x=632; tick 159 gives ball_x=630, with y still decreasing.
- paddle_x=0 after launch -> tick 118 gives ball_y=472 and miss high for exactly one clk. Next tick -> serving=1, ball (316,236). The following launch moves ball_x to 314 (direction inverted).
- Ball at (316,236) with visible=1: x=316,y=236 -> ball_pixel=1 one cycle later. x=324 -> 0. visible=0 with x=316 -> 0. frame_tick held 3 cycles in SERVE -> counter +3.
- reset asserted for one cycle mid-MOVING while miss is pending -> next cycle ball (316,236), serving=1, miss=0, ball_pixel=0.
